// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and transmitter state encoding
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 1250;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter with sync clear and a 1-cycle bit_done pulse
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic hwclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_done = enable && cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge hwclk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= bit_done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: valid/ready UART transmitter, 8 data bits, no parity, 1 or 2 stop bits
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);
  state_t     state;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       bit_done;
  logic       last_data, last_stop;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .hwclk    (hwclk),
    .reset    (reset),
    .clear    (state == IDLE),
    .enable   (state != IDLE),
    .bit_done (bit_done)
  );
  assign tx_ready  = state == IDLE;
  assign tx_busy   = !tx_ready;
  assign last_data = bit_idx == 3'(UART_DATA_BITS - 1);
  assign last_stop = bit_idx == 3'(STOP_BITS - 1);
  // shift moves right each data bit so the next bit out is always shift[1]
  always_ff @(posedge hwclk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_idx <= '0;
      shift   <= '0;
    end else
      case (state)
        IDLE: if (tx_valid) begin
          state <= START;
          tx    <= 1'b0;
          shift <= tx_data;
        end
        START: if (bit_done) begin
          state   <= DATA;
          tx      <= shift[0];
          bit_idx <= '0;
        end
        DATA: if (bit_done) begin
          state   <= last_data ? STOP : DATA;
          tx      <= last_data ? 1'b1 : shift[1];
          shift   <= shift >> 1;
          bit_idx <= last_data ? '0 : bit_idx + 1'b1;
        end
        STOP: if (bit_done) begin
          state   <= last_stop ? IDLE : STOP;
          bit_idx <= last_stop ? '0 : bit_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: table-driven and randomized frame checks against a per-cycle waveform model
module tb_uart_tx_8n1;
  localparam int C = 4;
  localparam int T = 10;
  typedef struct {
    logic [7:0] data;
    int         s;
    bit         hold;
    logic [7:0] alt;
    int         len;
  } vec_t;
  logic            hwclk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      valid = '0;
  logic [1:0][7:0] data  = '0;
  logic [1:0]      txs, readys, busys;
  int              checks = 0;
  int              errors = 0;
  time             start_t, prev_t;
  vec_t            tbl [6];
  always #(T/2) hwclk = ~hwclk;
  uart_tx_8n1 #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .hwclk(hwclk), .reset(reset), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(readys[0]), .tx(txs[0]), .tx_busy(busys[0]));
  uart_tx_8n1 #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .hwclk(hwclk), .reset(reset), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(readys[1]), .tx(txs[1]), .tx_busy(busys[1]));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // line level for every cycle of a frame: start, 8 data LSB first, stop bits
  function automatic logic [63:0] model(input logic [7:0] b, input int stops);
    logic [63:0] w = '0;
    for (int c = 0; c < (9 + stops) * C; c++) begin
      int p = c / C;
      w[c] = p == 0 ? 1'b0 : p <= 8 ? b[p-1] : 1'b1;
    end
    return w;
  endfunction
  function automatic logic [7:0] decode(input logic [63:0] w);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = w[(i + 1) * C + C / 2];
    return d;
  endfunction
  task automatic idle_check(input int s, input int n);
    int ok = 0;
    repeat (n) begin
      ok += int'(txs[s] && readys[s] && !busys[s]);
      @(negedge hwclk);
    end
    chk("idle_hold", ok, n);
  endtask
  task automatic frame(input int s, input logic [7:0] b, input bit hold, input logic [7:0] alt, input int len);
    logic [63:0] seen = '0;
    int ready_hi = 0;
    int to = 0;
    data[s]  = b;
    valid[s] = 1'b1;
    while (!readys[s] && to < 200) begin
      @(negedge hwclk);
      to++;
    end
    chk("accept_wait", to < 200, 1);
    @(negedge hwclk);
    start_t = $time;
    if (!hold) valid[s] = 1'b0;
    data[s] = alt;
    for (int k = 0; k < len; k++) begin
      seen[k] = txs[s];
      ready_hi += int'(readys[s]);
      @(negedge hwclk);
    end
    chk("waveform", seen, model(b, s + 1));
    chk("ready_low", ready_hi, 0);
    chk("end_idle", {txs[s], readys[s], busys[s]}, 3'b110);
    chk("decode", decode(seen), b);
    chk("low_cycles", len - $countones(seen), C * (9 - $countones(b)));
  endtask
  initial begin
    tbl = '{
      '{8'hA5, 0, 1'b0, 8'h5A, 40},
      '{8'h00, 0, 1'b1, 8'hFF, 40},
      '{8'hFF, 0, 1'b0, 8'h00, 40},
      '{8'h55, 0, 1'b0, 8'h3C, 40},
      '{8'h7E, 1, 1'b1, 8'h81, 44},
      '{8'h81, 1, 1'b0, 8'h7E, 44}
    };
    #1 reset = 1'b1;
    repeat (2) @(negedge hwclk);
    chk("reset_dut1", {txs[0], readys[0], busys[0]}, 3'b110);
    chk("reset_dut2", {txs[1], readys[1], busys[1]}, 3'b110);
    reset = 1'b0;
    idle_check(0, 20);
    for (int i = 0; i < 6; i++) begin
      prev_t = start_t;
      frame(tbl[i].s, tbl[i].data, tbl[i].hold, tbl[i].alt, tbl[i].len);
      if (i > 0 && tbl[i-1].hold) chk("start_gap", start_t - prev_t, (tbl[i-1].len + 1) * T);
      if (!tbl[i].hold) idle_check(tbl[i].s, 20);
    end
    valid = '0;
    for (int i = 0; i < 12; i++) begin
      int s = int'($urandom_range(0, 1));
      frame(s, 8'($urandom), 1'b0, 8'($urandom), (10 + s) * C);
    end
    data[0]  = 8'h81;
    valid[0] = 1'b1;
    @(negedge hwclk);
    valid[0] = 1'b0;
    repeat (10) @(negedge hwclk);
    chk("pre_reset_tx", txs[0], 0);
    reset = 1'b1;
    #1;
    chk("async_reset", {txs[0], readys[0], busys[0]}, 3'b110);
    @(negedge hwclk);
    reset = 1'b0;
    frame(0, 8'h42, 1'b0, 8'hBD, 40);
    idle_check(0, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Serial UART transmitter. Sends one 8-bit byte per valid/ready handshake as a standard 8N1 frame (configurable stop bits) on a single output pin.
- It is the transmit counterpart to the board's UART receive path and echo logic. Upstream logic hands it bytes; it drives the board's FTDI TX line.
- Bit timing is derived from hwclk by an integer clocks-per-bit divider.

Parameters:
- CLKS_PER_BIT, 1250, hwclk cycles per UART bit (12 MHz / 9600 baud); legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- hwclk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tx_data  input  8  byte to send; sampled only on handshake
- tx_valid  input  1  upstream has a byte
- tx_ready  output  1  block can accept a byte (high only in IDLE)
- tx  output  1  serial line, idle-high, registered
- tx_busy  output  1  frame in progress (not IDLE)

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock hwclk. All state is updated on the posedge of hwclk.
- Reset values:
  - state = IDLE, tx = 1, tx_ready = 1, tx_busy = 0.
  - Bit counter = 0, baud counter = 0, shift register = 0.
- Handshake:
  - A transfer occurs on any rising edge where tx_valid and tx_ready are both high.
  - tx_data is latched into the shift register on that edge. Later changes to tx_data do not affect the frame.
  - tx_ready = (state == IDLE). It is decoded combinationally from the registered state.
- States and transitions:
  - IDLE: tx = 1. On handshake, go to START, clear the baud counter, and set tx = 0 at the same edge.
  - START: hold tx = 0 for CLKS_PER_BIT cycles. Then go to DATA with bit index 0 and tx = shift[0].
  - DATA: each bit is held for CLKS_PER_BIT cycles, sent LSB first. After bit 7 completes, go to STOP with tx = 1.
  - STOP: hold tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
- Timing:
  - The frame occupies exactly (9+STOP_BITS)*CLKS_PER_BIT cycles, measured from the handshake edge to the edge returning to IDLE.
  - The first start-bit cycle is visible immediately after the handshake edge (latency 1 edge).
  - With tx_valid held high continuously, consecutive frames are separated by exactly 1 hwclk cycle of IDLE (tx = 1).
- Baud counter:
  - Width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - The bit-boundary event is counter == CLKS_PER_BIT-1.
  - The stop phase reuses the bit counter to count STOP_BITS bit periods.
- Boundary conditions:
  - tx_valid while busy: ignored, no latch. Upstream must hold tx_valid until it sees tx_ready.
  - Reset mid-frame: tx returns to 1 asynchronously and the frame is abandoned. After reset release, the first handshake starts a fresh frame.
  - tx_valid asserted in the same cycle reset deasserts: accepted on the first clock edge after release, provided reset is low at that edge.
- Glitch-free output: tx is a flop output, never combinational.

Decomposition:
- Package uart_pkg:
  - State encoding localparams: IDLE, START, DATA, STOP (2-bit).
  - UART_DATA_BITS = 8.
  - DEFAULT_CLKS_PER_BIT = 1250.
- Sub-module uart_baud_tick:
  - Parameterised counter with a synchronous clear input.
  - Emits a 1-cycle bit_done pulse every CLKS_PER_BIT cycles while enabled.
  - The matching RX block will reuse it with a half-bit preload.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- Reset check: assert reset with tx_valid=0 -> tx=1, tx_ready=1, tx_busy=0. Hold 20 idle cycles -> tx stays 1.
- Single byte 0xA5: one-cycle tx_valid -> tx sequence low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. tx_ready low for 40 cycles. Bench receiver decodes 0xA5.
- Back-to-back 0x00 then 0xFF with tx_valid held -> second start bit begins exactly 41 cycles after the first. 0x00 frame shows tx low for 36 consecutive cycles.
- tx_data changed to 0x3C mid-frame of 0x55, with tx_valid low -> 0x55 transmitted intact, no second frame.
- Reset asserted at cycle 10 of a 0x81 frame -> tx=1 immediately. After release, sending 0x42 produces a clean frame decoding to 0x42.
- STOP_BITS=2, byte 0x7E -> stop high 8 cycles, frame 44 cycles. tx_valid held high during the frame produces no early accept.
